// File: rtl/alu_sequencer.sv
// Command sequencer for an external arithmetic unit: accepts one operation,
// issues it, waits a bounded time for the result and holds it until consumed.
module alu_sequencer #(
   parameter int unsigned inWidth  = 7,
   parameter int unsigned outWidth = 15,
   parameter int unsigned TIMEOUT  = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CMD_VALID,
   output logic                CMD_READY,
   input  logic [inWidth:0]    CMD_A,
   input  logic [inWidth:0]    CMD_B,
   input  logic [1:0]          CMD_FUN,
   output logic [inWidth:0]    A,
   output logic [inWidth:0]    B,
   output logic [1:0]          ALU_FUN,
   output logic                Arith_Enable,
   input  logic [outWidth:0]   Arith_OUT,
   input  logic                Carry_OUT,
   input  logic                Arith_Flag,
   output logic                RES_VALID,
   input  logic                RES_READY,
   output logic [outWidth:0]   RES_DATA,
   output logic                RES_CARRY,
   output logic                RES_ERR,
   output logic                BUSY,
   output logic [15:0]         OP_COUNT
);

   localparam int unsigned OPW = inWidth + 1;
   localparam int unsigned RW  = outWidth + 1;
   localparam int unsigned CNTW = 16;
   localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] FUN_ADD = 2'b00;
   localparam logic [1:0] FUN_SUB = 2'b01;
   localparam logic [1:0] FUN_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     wait_cnt, wait_cnt_n;
   logic [OPW-1:0]    a_n, b_n;
   logic [1:0]        fun_n;
   logic              en_n, valid_n, carry_n, err_n;
   logic [RW-1:0]     data_n;
   logic [CNTW-1:0]   count_n;
   logic              carry_c;

   // Carry_OUT is deliberately ignored; carry is reconstructed from the operands.
   logic unused_carry_out;
   assign unused_carry_out = Carry_OUT;

   // Result carry derived from the latched operation.
   always_comb begin
      carry_c = 1'b0;
      case (ALU_FUN)
         FUN_ADD: carry_c = Arith_OUT[OPW];
         FUN_SUB: carry_c = (A < B);
         default: carry_c = 1'b0;
      endcase
   end

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      a_n        = A;
      b_n        = B;
      fun_n      = ALU_FUN;
      en_n       = 1'b0;
      valid_n    = RES_VALID;
      data_n     = RES_DATA;
      carry_n    = RES_CARRY;
      err_n      = RES_ERR;
      count_n    = OP_COUNT;
      case (state)
         IDLE: begin
            if (CMD_VALID && CMD_READY) begin
               a_n   = CMD_A;
               b_n   = CMD_B;
               fun_n = CMD_FUN;
               // Divide by zero never reaches the unit.
               if ((CMD_FUN == FUN_DIV) && (CMD_B == '0)) begin
                  state_n = HOLD;
                  valid_n = 1'b1;
                  err_n   = 1'b1;
                  data_n  = '0;
                  carry_n = 1'b0;
               end else begin
                  state_n = ISSUE;
                  en_n    = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_n    = WAIT;
            wait_cnt_n = '0;
         end
         WAIT: begin
            if (Arith_Flag) begin
               state_n = HOLD;
               valid_n = 1'b1;
               data_n  = Arith_OUT;
               err_n   = 1'b0;
               carry_n = carry_c;
            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
               state_n = HOLD;
               valid_n = 1'b1;
               data_n  = '0;
               err_n   = 1'b1;
               carry_n = 1'b0;
            end else begin
               wait_cnt_n = wait_cnt + CW'(1);
            end
         end
         HOLD: begin
            if (RES_READY) begin
               state_n = IDLE;
               valid_n = 1'b0;
               count_n = OP_COUNT + CNTW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Every output is a flop loaded from its next-state value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         CMD_READY    <= 1'b1;
         BUSY         <= 1'b0;
         A            <= '0;
         B            <= '0;
         ALU_FUN      <= '0;
         Arith_Enable <= 1'b0;
         RES_VALID    <= 1'b0;
         RES_DATA     <= '0;
         RES_CARRY    <= 1'b0;
         RES_ERR      <= 1'b0;
         OP_COUNT     <= '0;
      end else begin
         state        <= state_n;
         wait_cnt     <= wait_cnt_n;
         CMD_READY    <= (state_n == IDLE);
         BUSY         <= (state_n != IDLE);
         A            <= a_n;
         B            <= b_n;
         ALU_FUN      <= fun_n;
         Arith_Enable <= en_n;
         RES_VALID    <= valid_n;
         RES_DATA     <= data_n;
         RES_CARRY    <= carry_n;
         RES_ERR      <= err_n;
         OP_COUNT     <= count_n;
      end
   end

endmodule
